mux4_rr_arbiter: RTL and testbench

Round-robin arbiter and sequencer for the 4:1 single-bit data mux. It shares the mux among four requesters, drives the mux select lines from the current grant, and presents the selected data bit. A grant is held until the owner releases it or, optionally, until a hold timeout forces rotation.

---
 rtl/mux4_arb_pkg.sv | 19 +
 rtl/mux4_rr_arbiter_pick.sv | 31 +++
 rtl/mux4_rr_arbiter.sv | 145 ++++++++++++++
 tb/tb_mux4_rr_arbiter.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/mux4_arb_pkg.sv
// Shared types and helpers for the 4:1 mux round-robin arbiter.
//   state_t     : arbiter FSM states
//   NREQ, IDX_W : requester count and index width
//   idx2onehot  : 2-bit index to 4-bit one-hot grant vector
package mux4_arb_pkg;

   localparam int unsigned NREQ  = 4;
   localparam int unsigned IDX_W = 2;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   function automatic logic [NREQ-1:0] idx2onehot(input logic [IDX_W-1:0] idx);
      idx2onehot = NREQ'(1) << idx;
   endfunction

endpackage

// File: rtl/mux4_rr_arbiter_pick.sv
// rr_pick4: combinational round-robin picker.
//   mask : candidate requests
//   ptr  : first index considered (highest priority)
//   any  : at least one candidate present
//   idx  : first asserted mask bit scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4)
module rr_pick4
   import mux4_arb_pkg::*;
(
   input  logic [NREQ-1:0]  mask,
   input  logic [IDX_W-1:0] ptr,
   output logic             any,
   output logic [IDX_W-1:0] idx
);

   logic [IDX_W-1:0] cand;

   // Scan from the lowest priority upward so the last hit wins (closest to ptr).
   always_comb begin
      any  = 1'b0;
      idx  = ptr;
      cand = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         cand = ptr + IDX_W'(i);
         if (mask[cand]) begin
            any = 1'b1;
            idx = cand;
         end
      end
   end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin arbiter/sequencer for a shared 4:1 1-bit mux.
//   clk, rst_n         : clock, asynchronous active-low reset
//   req[3:0]           : per-requester request, held while the mux is wanted
//   data0..data3       : per-requester data bit
//   grant[3:0]         : registered one-hot grant (zero when idle)
//   sel0, sel1         : registered mux select, {sel1,sel0} = granted index
//   busy               : registered, high while a grant is active
//   out                : combinational data of the granted requester, 0 when idle
// Build option: define MUX4_ARB_TIMEOUT_EN to force rotation after HOLD_MAX
// consecutive grant cycles when another requester is waiting.
module mux4_rr_arbiter
   import mux4_arb_pkg::*;
#(
   parameter int unsigned HOLD_MAX = 8,
   parameter int unsigned CNT_W    = 8
)(
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NREQ-1:0] req,
   input  logic            data0,
   input  logic            data1,
   input  logic            data2,
   input  logic            data3,
   output logic [NREQ-1:0] grant,
   output logic            sel0,
   output logic            sel1,
   output logic            busy,
   output logic            out
);

   // Elaboration-time parameter sanity check.
   if ((HOLD_MAX < 2) || (HOLD_MAX > 255) || ((2 ** CNT_W) <= HOLD_MAX)) begin : g_bad_cfg
      $error("mux4_rr_arbiter: illegal HOLD_MAX/CNT_W combination");
   end

   state_t           state_q, state_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [NREQ-1:0]  grant_q, grant_d;
   logic [IDX_W-1:0] sel_q, sel_d;
   logic             busy_q, busy_d;

   logic             pick_any;
   logic [IDX_W-1:0] pick_idx;
   logic             owner_req;
   logic             timeout;
   logic             take;
   logic [NREQ-1:0]  data_v;

   // Masking out the owner covers IDLE too, since grant is zero there.
   rr_pick4 u_pick (
      .mask (req & ~grant_q),
      .ptr  (ptr_q),
      .any  (pick_any),
      .idx  (pick_idx)
   );

   assign owner_req = |(req & grant_q);

`ifdef MUX4_ARB_TIMEOUT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Counter reads k-1 at the k-th edge of a grant, so HOLD_MAX-1 marks rotation.
   assign timeout = (cnt_q >= CNT_W'(HOLD_MAX - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end
`else
   assign timeout = 1'b0;
`endif

   // Next-state and registered-output logic.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      grant_d = grant_q;
      sel_d   = sel_q;
      busy_d  = busy_q;
      take    = 1'b0;
`ifdef MUX4_ARB_TIMEOUT_EN
      cnt_d   = cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (pick_any) take = 1'b1;
         end
         GRANT: begin
            if (!owner_req) begin
               if (pick_any) begin
                  take = 1'b1;
               end else begin
                  state_d = IDLE;
                  grant_d = '0;
                  busy_d  = 1'b0;
               end
            end else if (timeout) begin
               if (pick_any) take = 1'b1;
`ifdef MUX4_ARB_TIMEOUT_EN
               else          cnt_d = '0;
            end else if (cnt_q != {CNT_W{1'b1}}) begin
               cnt_d = cnt_q + CNT_W'(1);
`endif
            end
         end
         default: state_d = IDLE;
      endcase

      if (take) begin
         state_d = GRANT;
         grant_d = idx2onehot(pick_idx);
         sel_d   = pick_idx;
         busy_d  = 1'b1;
         ptr_d   = pick_idx + IDX_W'(1);
`ifdef MUX4_ARB_TIMEOUT_EN
         cnt_d   = '0;
`endif
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         grant_q <= '0;
         sel_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         sel_q   <= sel_d;
         busy_q  <= busy_d;
      end
   end

   assign data_v = {data3, data2, data1, data0};
   assign grant  = grant_q;
   assign sel0   = sel_q[0];
   assign sel1   = sel_q[1];
   assign busy   = busy_q;
   assign out    = busy_q & data_v[sel_q];

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: expected grant/sel/busy are queued when a
// step is driven and popped when the step's clock edge has produced output.
// Handles both the default build and MUX4_ARB_TIMEOUT_EN (HOLD_MAX = 8).
module tb_mux4_rr_arbiter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] req = 4'b0000;
   logic       data0 = 1'b0, data1 = 1'b0, data2 = 1'b0, data3 = 1'b0;
   logic [3:0] grant;
   logic       sel0, sel1, busy, out;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [3:0] grant;
      logic [1:0] sel;
      logic       busy;
   } exp_t;

   exp_t sbq[$];

   mux4_rr_arbiter #(.HOLD_MAX(8), .CNT_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req),
      .data0 (data0),
      .data1 (data1),
      .data2 (data2),
      .data3 (data3),
      .grant (grant),
      .sel0  (sel0),
      .sel1  (sel1),
      .busy  (busy),
      .out   (out)
   );

   always #5 clk = ~clk;

   function automatic exp_t mk(input logic [1:0] idx, input logic b);
      exp_t e;
      logic [3:0] one;
      one     = 4'b0001;
      e.grant = b ? (one << idx) : 4'b0000;
      e.sel   = idx;
      e.busy  = b;
      return e;
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic check_exp(input string tag, input exp_t e);
      logic [3:0] dv;
      logic       eo;
      dv = {data3, data2, data1, data0};
      eo = e.busy ? dv[e.sel] : 1'b0;
      chk({tag, ".grant"}, 8'(grant), 8'(e.grant));
      chk({tag, ".sel"},   8'({sel1, sel0}), 8'(e.sel));
      chk({tag, ".busy"},  8'(busy), 8'(e.busy));
      chk({tag, ".out"},   8'(out), 8'(eo));
   endtask

   // One clock step: drive req and fresh random data, queue the expectation,
   // then compare just after the edge.
   task automatic cyc(input string tag, input logic [3:0] r, input exp_t e);
      logic [3:0] d;
      req = r;
      d = 4'($urandom);
      {data3, data2, data1, data0} = d;
      sbq.push_back(e);
      @(posedge clk);
      #1;
      check_exp(tag, sbq.pop_front());
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int owner;

      // Reset held with all requests asserted.
      req = 4'b1111;
      repeat (3) @(posedge clk);
      #1;
      check_exp("in_reset", mk(2'd0, 1'b0));
      @(negedge clk) rst_n = 1'b1;

      // First arbitration from ptr = 0.
      cyc("first", 4'b1111, mk(2'd0, 1'b1));
      data0 = 1'b1; #1; chk("out_d0_hi", 8'(out), 8'd1);
      data0 = 1'b0; #1; chk("out_d0_lo", 8'(out), 8'd0);
      cyc("idle0", 4'b0000, mk(2'd0, 1'b0));

      // Request that drops before being sampled.
      @(negedge clk) req = 4'b0010;
      #2 req = 4'b0000;
      cyc("glitch", 4'b0000, mk(2'd0, 1'b0));

      // Single requester 2, data2 toggling.
      cyc("solo", 4'b0100, mk(2'd2, 1'b1));
      for (int i = 0; i < 3; i++) cyc("solo_hold", 4'b0100, mk(2'd2, 1'b1));
      data2 = 1'b1; #1; chk("out_d2_hi", 8'(out), 8'd1);
      data2 = 1'b0; #1; chk("out_d2_lo", 8'(out), 8'd0);
      cyc("solo_rel", 4'b0000, mk(2'd2, 1'b0));

      // All requesting, owners dropping in turn: zero-bubble rotation (ptr = 3).
      cyc("rot0", 4'b1111, mk(2'd3, 1'b1));
      cyc("rot1", 4'b0111, mk(2'd0, 1'b1));
      cyc("rot2", 4'b1110, mk(2'd1, 1'b1));
      cyc("rot3", 4'b1101, mk(2'd2, 1'b1));
      cyc("rot4", 4'b1011, mk(2'd3, 1'b1));
      cyc("rot5", 4'b0111, mk(2'd0, 1'b1));

      // Asynchronous reset in the middle of a grant to requester 3.
      cyc("pre_rst", 4'b1000, mk(2'd3, 1'b1));
      #2 rst_n = 1'b0;
      #1;
      check_exp("async_rst", mk(2'd0, 1'b0));
      req = 4'b1001;
      @(negedge clk) rst_n = 1'b1;
      cyc("post_rst", 4'b1001, mk(2'd0, 1'b1));
      cyc("drop", 4'b0000, mk(2'd0, 1'b0));

      // Two contending requesters held; ptr = 1 so requester 1 goes first.
`ifdef MUX4_ARB_TIMEOUT_EN
      for (int k = 0; k < 40; k++) begin
         owner = (((k / 8) % 2) == 0) ? 1 : 0;
         cyc("contend_to", 4'b0011, mk(2'(owner), 1'b1));
      end
`else
      for (int k = 0; k < 50; k++) begin
         owner = 1;
         cyc("contend", 4'b0011, mk(2'(owner), 1'b1));
      end
`endif

      // Requester 1 leaves; requester 0 alone keeps the grant indefinitely.
      for (int k = 0; k < 30; k++) cyc("alone", 4'b0001, mk(2'd0, 1'b1));
      cyc("final_idle", 4'b0000, mk(2'd0, 1'b0));

      chk("sb_empty", 8'(sbq.size()), 8'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
